// File: rtl/regfile_pkg.sv
// Shared types and helpers for the clearable register file.
// Optional feature macro used by reg_file_clr: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  typedef enum logic {IDLE, CLEAR} rf_state_t;

  // A write lands only when requested, no sweep is running, the address exists
  // and it does not target a hardwired-zero entry.
  function automatic logic wr_accept(input logic wr_en,
                                     input logic busy,
                                     input logic addr_ok,
                                     input logic zero_hit);
    return wr_en && !busy && addr_ok && !zero_hit;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks clr_idx from 0 to DEPTH-1, one entry per cycle,
// holding busy high for exactly DEPTH cycles.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_active,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t     state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic          busy_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      busy  <= busy_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          idx_n   = '0;
          busy_n  = 1'b1;
        end
      end
      CLEAR: begin
        // clr is deliberately ignored here: no restart, no queueing.
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
          busy_n  = 1'b0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign clr_active = (state == CLEAR);
  assign clr_idx    = idx;

endmodule

// File: rtl/reg_file_clr.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port,
// optional hardwired-zero entry 0, sequenced bulk clear. Macro: REGFILE_BYPASS_EN.
module reg_file_clr
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 32,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  output logic             busy
);

  localparam bit FULL_RANGE = (DEPTH == (1 << AW));

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_active;
  logic [AW-1:0]    clr_idx;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_in_range [2];
  logic             rd_ok [2];
  logic             wr_in_range;
  logic             wr_ok;

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_data1   = rd_data[0];
  assign rd_data2   = rd_data[1];

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .busy       (busy),
    .clr_active (clr_active),
    .clr_idx    (clr_idx)
  );

  // With a power-of-two depth every address is valid; otherwise compare.
  if (FULL_RANGE) begin : g_full
    assign wr_in_range    = 1'b1;
    assign rd_in_range[0] = 1'b1;
    assign rd_in_range[1] = 1'b1;
  end else begin : g_partial
    assign wr_in_range    = ({1'b0, wr_addr}     < (AW+1)'(DEPTH));
    assign rd_in_range[0] = ({1'b0, rd_addr[0]}  < (AW+1)'(DEPTH));
    assign rd_in_range[1] = ({1'b0, rd_addr[1]}  < (AW+1)'(DEPTH));
  end

  assign wr_ok = wr_accept(wr_en, busy, wr_in_range, ZERO_REG && (wr_addr == '0));

  // NOTE: the array is flop-based, so it can honour the asynchronous reset;
  // an SRAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_active) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_ok[p]   = rd_in_range[p] && !(ZERO_REG && (rd_addr[p] == '0));
      rd_data[p] = '0;
      if (rd_ok[p]) rd_data[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes zero/out-of-range targets, so those rules still win.
      if (rd_ok[p] && wr_ok && (wr_addr == rd_addr[p])) rd_data[p] = wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_clr.sv
// Self-checking bench for reg_file_clr (DEPTH=20, ZERO_REG=1): vector table,
// hand-written clear/reset sequences and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_reg_file_clr;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    rd_addr1, rd_addr2, wr_addr;
  logic [WIDTH-1:0] rd_data1, rd_data2, wr_data;
  logic             wr_en, clr, busy;

  reg_file_clr #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr      (clr),
    .busy     (busy)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents plus remaining sweep position.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_busy = 1'b0;
  int               m_idx  = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [31:0]   e1;
    logic [31:0]   e2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_accept(input logic we, input logic [AW-1:0] wa);
    return we && !m_busy && (int'(wa) < DEPTH) && (wa != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (m_accept(wr_en, wr_addr) && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic [31:0] fill_val(input int k);
    return (32'h01010101 * k) ^ 32'h5A000000;
  endfunction

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic step();
    bit acc;
    acc = m_accept(wr_en, wr_addr);
    @(posedge clk);
    if (m_busy) begin
      m_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) m_busy = 1'b0;
    end else begin
      if (acc) m_mem[wr_addr] = wr_data;
      if (clr) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] d;

    model_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    #20;
    check("busy_in_reset", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Reset state: every address (including out-of-range) reads 0.
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(31 - a);
      #1;
      check("reset_rd1", rd_data1, 32'd0);
      check("reset_rd2", rd_data2, 32'd0);
    end
    check("reset_busy", 32'(busy), 32'd0);

    // Vector table: write, then read back after the edge.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd25, 32'h0000CAFE, 5'd25, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd19, 32'h12345678, 5'd19, 5'd18, 32'h12345678, 32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd19, 32'hFFFFFFFF, 32'h12345678};
    vecs[5] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd1,  32'hDEADBEEF, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd0,  32'h00000001, 32'h0};
    for (int i = 0; i < 7; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr1 = vecs[i].ra1; rd_addr2 = vecs[i].ra2;
      step();
      wr_en = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), rd_data1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd_data2, vecs[i].e2);
    end

    // Same-cycle write/read on addr 7: forwarded only with the bypass build.
    write(5'd7, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_addr1 = 5'd7; rd_addr2 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd_data1, 32'hA5A5A5A5);
`else
    check("bypass_same_cycle", rd_data1, 32'h11111111);
`endif
    check("bypass_other_port", rd_data2, 32'h00000001);
    step();
    wr_en = 1'b0;
    #1;
    check("bypass_next_cycle", rd_data1, 32'hA5A5A5A5);

    // Fill every entry, then sweep.
    for (int k = 1; k < DEPTH; k++) write(AW'(k), fill_val(k));
    clr = 1'b1;
    step();
    clr = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        rd_addr1 = AW'(k); rd_addr2 = AW'(DEPTH - 1 - k);
        #1;
        check("sweep_rd1", rd_data1, (k == 0 || k < c) ? 32'd0 : fill_val(k));
        check("sweep_rd2", rd_data2, ((DEPTH - 1 - k) == 0 || (DEPTH - 1 - k) < c) ? 32'd0 : fill_val(DEPTH - 1 - k));
      end
      check("sweep_busy", 32'(busy), (c < DEPTH) ? 32'd1 : 32'd0);
      if (!busy) break;
      busy_cnt++;
      // Dropped write and ignored second clr mid-sweep.
      if (c == 5) begin
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd15; wr_data = 32'hBAD0BAD0;
      end
      step();
      clr = 1'b0; wr_en = 1'b0;
    end
    check("sweep_busy_cycles", 32'(busy_cnt), 32'(DEPTH));

    // Write and clr on the same IDLE edge: write lands, then gets swept.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33333333; clr = 1'b1;
    step();
    wr_en = 1'b0; clr = 1'b0;
    rd_addr1 = 5'd3;
    #1;
    check("wrclr_written", rd_data1, 32'h33333333);
    check("wrclr_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 3 * DEPTH && busy; c++) step();
    #1;
    check("wrclr_swept", rd_data1, 32'd0);
    check("wrclr_done", 32'(busy), 32'd0);

    // Reset asserted between edges in the middle of a sweep.
    for (int k = 1; k < DEPTH; k++) write(AW'(k), fill_val(k) ^ 32'hFFFF0000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < 4; c++) step();
    #2 rst_n = 1'b0;
    #1;
    check("midsweep_reset_busy", 32'(busy), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr1 = AW'(k); rd_addr2 = AW'(k);
      #1;
      check("midsweep_reset_rd1", rd_data1, 32'd0);
      check("midsweep_reset_rd2", rd_data2, 32'd0);
    end
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = AW'($urandom_range(0, 31));
      d        = $urandom;
      wr_data  = d;
      clr      = ($urandom_range(0, 39) == 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      rd_addr2 = AW'($urandom_range(0, 31));
      #1;
      check("rand_rd1", rd_data1, exp_rd(rd_addr1));
      check("rand_rd2", rd_data2, exp_rd(rd_addr2));
      check("rand_busy", 32'(busy), 32'(m_busy));
      step();
    end
    wr_en = 1'b0; clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
